pc_sequencer: RTL
=================

# pc_sequencer

Sequential program-counter owner for the CPU datapath. Holds the PC, runs the instruction-fetch handshake with instruction memory, and applies the 2-bit `sel` next-PC code produced by the branch-condition logic once the decode stage marks it valid. Sits between the branch/flag combinational logic (upstream of `sel`) and the instruction memory port.

## Interface

Parameters:
- `AW`, 8: PC / address width.
- `RESET_PC`, 0: PC value loaded on reset.
- `RAS_DEPTH`, 4: return-address-stack entries, power of two; used only with `PC_RAS_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `run`  in  1  when low, the block parks in IDLE after the current instruction.
- `sel`  in  2  next-PC code: 00 = PC+1, 01 = PC+`offset`, 10 = `target`, 11 = return/hold.
- `sel_valid`  in  1  `sel`, `offset`, `target` and `call` valid this cycle.
- `offset`  in  AW  signed two's-complement relative displacement.
- `target`  in  AW  absolute jump address.
- `call`  in  1  push the return address on a taken 01/10 (RAS only).
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  AW  fetch address, equal to `pc`.
- `imem_ack`  in  1  memory accepted and returned the word this cycle.
- `instr_valid`  out  1  one-cycle pulse: fetched word available to decode.
- `pc`  out  AW  current PC.
- `ras_err`  out  1  one-cycle pulse on RAS overflow/underflow (RAS only; constant 0 otherwise).

## Operation

- FSM states: IDLE, FETCH, DECODE.
- IDLE: `imem_req`=0. If `run`=1, go to FETCH the next cycle.
- FETCH: `imem_req`=1 and `imem_addr`=`pc`, both held stable until `imem_ack`=1 is sampled. On ack: pulse `instr_valid` the next cycle and enter DECODE.
- DECODE: wait for `sel_valid`. When it arrives, load the next PC per `sel`, then go to FETCH if `run`=1, else IDLE. `sel_valid` in IDLE or FETCH is ignored.
- Arithmetic is modulo 2^AW. PC+1 wraps from all-ones to 0. PC+`offset` uses a sign-extended add and ignores the carry out.
- `sel`=11 without the RAS: PC unchanged, so the same address is refetched. This is the hold/spin case.
- `imem_ack` outside FETCH is ignored.
- `call` with `sel`=00 is ignored.

## Timing

- Reset values: state=IDLE, `pc`=`RESET_PC`, `imem_req`=0, `instr_valid`=0, `ras_err`=0, RAS pointer and count=0.
- Reset mid-fetch abandons the request. `imem_req` is low in the cycle after `rst` is sampled high.
- Minimum throughput: 2 cycles per instruction.
  - Req at cycle N, ack at N.
  - DECODE and `instr_valid` at N+1, `sel_valid` at N+1.
  - New `pc` and req at N+2.
- `pc` changes only on the edge that consumes `sel_valid` in DECODE.
- `instr_valid` is exactly one cycle wide per acked fetch.

## Configuration

- `PC_RAS_EN` defined: a `RAS_DEPTH`-entry return-address stack is compiled in.
  - Push: on a consumed `sel` of 01 or 10 with `call`=1, PC+1 is pushed.
  - Pop: `sel`=11 loads `pc` from the stack top and pops. `call` is ignored for 11.
  - Push when full: overwrite the oldest entry (circular), count stays `RAS_DEPTH`, pulse `ras_err`.
  - Pop when empty: `pc`=`RESET_PC`, pulse `ras_err`.
- `PC_RAS_EN` undefined: no stack storage. `sel`=11 holds the PC, `call` is ignored, `ras_err` is tied to 0.

## Test plan

- Reset, then `run`=1, ack every fetch, `sel`=00 repeatedly with `AW`=8 -> `imem_addr` sequence 0,1,2,…; after 255 the next address is 0; one instruction per 2 cycles.
- At `pc`=0x10: `sel`=01, `offset`=0xFC -> next `imem_addr`=0x0C. Then `sel`=10, `target`=0x80 -> 0x80.
- Hold `imem_ack` low for 5 cycles in FETCH -> `imem_req` and `imem_addr` stay stable, no `instr_valid`, `pc` unchanged. Ack -> exactly one `instr_valid` pulse.
- Assert `rst` while `imem_req`=1 -> next cycle `imem_req`=0 and `pc`=`RESET_PC`. The late ack, and a `sel_valid` with `sel`=10, `target`=0x55 presented in that cycle, are both ignored (`pc` stays `RESET_PC`).
- With `PC_RAS_EN`: at `pc`=0x20, `sel`=10, `call`=1, `target`=0x40, then `sel`=11 -> PC returns to 0x21. Five nested calls at depth 4 -> `ras_err` on the 5th. A pop on an empty stack -> `pc`=`RESET_PC` and a `ras_err` pulse.
- Without `PC_RAS_EN`: `sel`=11 at `pc`=0x33 -> refetch at 0x33, `ras_err` stays 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter owner: fetch handshake plus next-PC select.
// Optional return-address stack compiled in with PC_RAS_EN.
module pc_sequencer #(
  parameter int AW = 8,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [1:0]    sel,
  input  logic          sel_valid,
  input  logic [AW-1:0] offset,
  input  logic [AW-1:0] target,
  input  logic          call,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          ras_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          iv_q, iv_d;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] ret_pc;
  logic          consume;

  assign pc_inc    = pc_q + AW'(1);
  assign consume   = (state_q == DECODE) && sel_valid;
  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr_valid = iv_q;

`ifdef PC_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [AW-1:0] ras_q [RAS_DEPTH];
  logic [AW-1:0] ras_d [RAS_DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          push, pop;

  assign push    = consume && call && (sel == 2'b01 || sel == 2'b10);
  assign pop     = consume && (sel == 2'b11);
  assign ret_pc  = (cnt_q == '0) ? RESET_PC : ras_q[ptr_q - PW'(1)];
  assign ras_err = err_q;

  // Stack update: circular push overwrites oldest when full.
  always_comb begin
    ras_d = ras_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (push) begin
      ras_d[ptr_q] = pc_inc;
      ptr_d = ptr_q + PW'(1);
      if (cnt_q == FULL) err_d = 1'b1;
      else cnt_d = cnt_q + CW'(1);
    end else if (pop) begin
      if (cnt_q == '0) begin
        err_d = 1'b1;
      end else begin
        ptr_d = ptr_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // Stack registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ras_q <= '{default: '0};
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      ras_q <= ras_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  logic unused_call;

  assign unused_call = call;
  assign ret_pc      = pc_q;
  assign ras_err     = 1'b0;
`endif

  // Next-state, next-PC and instr_valid pulse.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    iv_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          iv_d    = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (sel_valid) begin
          unique case (sel)
            2'b00: pc_d = pc_inc;
            2'b01: pc_d = pc_q + offset;
            2'b10: pc_d = target;
            2'b11: pc_d = ret_pc;
          endcase
          state_d = run ? FETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Core registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      iv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      iv_q    <= iv_d;
    end
  end

endmodule
